// File: rtl/rr_issue_scoreboard_if.sv
// Issue/register-read handshake bundle for rr_issue_scoreboard: decode side, register-read side,
// writeback feedback and status. The slave modport is the scoreboard, the master modport is its driver.
interface rr_issue_scoreboard_if #(
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned STALL_W  = 16
);
  logic                flush;
  logic                in_valid;
  logic                in_ready;
  logic [6:0]          in_ctrl;
  logic [31:0]         in_imm;
  logic [2:0]          in_src1_idx;
  logic [2:0]          in_src2_idx;
  logic [2:0]          in_dst_idx;
  logic                in_dst_we;
  logic                out_valid;
  logic                out_ready;
  logic [6:0]          out_ctrl;
  logic [31:0]         out_imm;
  logic [2:0]          out_src1_idx;
  logic [2:0]          out_src2_idx;
  logic [2:0]          out_dst_idx;
  logic                out_dst_we;
  logic                wb_we;
  logic [2:0]          wb_idx;
  logic [NUM_REGS-1:0] busy_vec;
  logic [STALL_W-1:0]  stall_cnt;
  logic                wb_underflow;

  modport master (
    output flush, in_valid, in_ctrl, in_imm, in_src1_idx, in_src2_idx, in_dst_idx, in_dst_we,
    output out_ready, wb_we, wb_idx,
    input  in_ready, out_valid, out_ctrl, out_imm, out_src1_idx, out_src2_idx, out_dst_idx,
    input  out_dst_we, busy_vec, stall_cnt, wb_underflow
  );

  modport slave (
    input  flush, in_valid, in_ctrl, in_imm, in_src1_idx, in_src2_idx, in_dst_idx, in_dst_we,
    input  out_ready, wb_we, wb_idx,
    output in_ready, out_valid, out_ctrl, out_imm, out_src1_idx, out_src2_idx, out_dst_idx,
    output out_dst_we, busy_vec, stall_cnt, wb_underflow
  );
endinterface

// File: rtl/rr_issue_scoreboard.sv
// Single-entry issue stage with per-register pending-write counters and RAW/WAW stalling.
// Optional macro WB_BYPASS_EN: a writeback retiring the last pending write clears its hazard same-cycle.
module rr_issue_scoreboard #(
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned PEND_W   = 2,
  parameter int unsigned STALL_W  = 16
) (
  input logic                  clk,
  input logic                  rst,
  rr_issue_scoreboard_if.slave bus
);
  localparam int unsigned IdxW = 3;
  localparam logic [PEND_W-1:0]  PendMax  = '1;
  localparam logic [STALL_W-1:0] StallMax = '1;

  logic                hold_valid_q;
  logic [6:0]          ctrl_q;
  logic [31:0]         imm_q;
  logic [IdxW-1:0]     src1_q, src2_q, dst_q;
  logic                dst_we_q;
  logic [PEND_W-1:0]   pend_q [NUM_REGS];
  logic [PEND_W-1:0]   pend_d [NUM_REGS];
  logic [STALL_W-1:0]  stall_q;
  logic                underflow_q, underflow_d;

  logic [NUM_REGS-1:0] busy, bypass, inc_vec, dec_vec;
  logic                src1_haz, src2_haz, dst_haz, hazard;
  logic                out_valid, issue, issue_upd, in_ready, accept;

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      busy[r]    = pend_q[r] != '0;
`ifdef WB_BYPASS_EN
      bypass[r]  = bus.wb_we && (bus.wb_idx == IdxW'(r)) && (pend_q[r] == PEND_W'(1));
`else
      bypass[r]  = 1'b0;
`endif
      inc_vec[r] = issue_upd && dst_we_q && (dst_q == IdxW'(r));
      dec_vec[r] = bus.wb_we && (bus.wb_idx == IdxW'(r));
    end
  end

  assign src1_haz  = busy[src1_q] && !bypass[src1_q];
  assign src2_haz  = !ctrl_q[6] && busy[src2_q] && !bypass[src2_q];
  assign dst_haz   = dst_we_q && (pend_q[dst_q] == PendMax) && !bypass[dst_q];
  assign hazard    = hold_valid_q && (src1_haz || src2_haz || dst_haz);
  assign out_valid = hold_valid_q && !hazard;
  assign issue     = out_valid && bus.out_ready;
  // A flush squashes a coincident issue, so its destination is never marked pending.
  assign issue_upd = issue && !bus.flush;
  assign in_ready  = bus.flush || !hold_valid_q || issue;
  assign accept    = bus.in_valid && in_ready && !bus.flush;

  always_comb begin
    underflow_d = underflow_q;
    for (int r = 0; r < NUM_REGS; r++) begin
      pend_d[r] = pend_q[r];
      if (inc_vec[r] && !dec_vec[r]) begin
        pend_d[r] = pend_q[r] + PEND_W'(1);
      end else if (dec_vec[r] && !inc_vec[r]) begin
        if (pend_q[r] == '0) underflow_d = 1'b1;
        else                 pend_d[r]   = pend_q[r] - PEND_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hold_valid_q <= 1'b0;
      ctrl_q       <= '0;
      imm_q        <= '0;
      src1_q       <= '0;
      src2_q       <= '0;
      dst_q        <= '0;
      dst_we_q     <= 1'b0;
      stall_q      <= '0;
      underflow_q  <= 1'b0;
      for (int r = 0; r < NUM_REGS; r++) pend_q[r] <= '0;
    end else begin
      if (bus.flush) begin
        hold_valid_q <= 1'b0;
      end else if (accept) begin
        hold_valid_q <= 1'b1;
        ctrl_q       <= bus.in_ctrl;
        imm_q        <= bus.in_imm;
        src1_q       <= bus.in_src1_idx;
        src2_q       <= bus.in_src2_idx;
        dst_q        <= bus.in_dst_idx;
        dst_we_q     <= bus.in_dst_we;
      end else if (issue) begin
        hold_valid_q <= 1'b0;
      end
      if (hazard && stall_q != StallMax) stall_q <= stall_q + STALL_W'(1);
      underflow_q <= underflow_d;
      for (int r = 0; r < NUM_REGS; r++) pend_q[r] <= pend_d[r];
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = out_valid;
  assign bus.out_ctrl     = ctrl_q;
  assign bus.out_imm      = imm_q;
  assign bus.out_src1_idx = src1_q;
  assign bus.out_src2_idx = src2_q;
  assign bus.out_dst_idx  = dst_q;
  assign bus.out_dst_we   = dst_we_q;
  assign bus.busy_vec     = busy;
  assign bus.stall_cnt    = stall_q;
  assign bus.wb_underflow = underflow_q;
endmodule

// File: tb/tb_rr_issue_scoreboard.sv
// Directed scenarios plus randomized traffic for rr_issue_scoreboard, checked against a
// cycle model kept as plain counts per register.
module tb_rr_issue_scoreboard;
  localparam int PendMax  = 3;
  localparam int StallMax = 65535;
`ifdef WB_BYPASS_EN
  localparam int RawStalls = 2;
`else
  localparam int RawStalls = 3;
`endif

  logic clk;
  logic rst;
  rr_issue_scoreboard_if bus ();

  rr_issue_scoreboard u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state
  int          m_pend [8];
  bit          m_hv;
  logic [6:0]  m_ctrl;
  logic [31:0] m_imm;
  logic [2:0]  m_s1, m_s2, m_d;
  bit          m_we;
  int          m_stall;
  bit          m_uf;
  bit          m_hazard, exp_out_valid, exp_in_ready;
  logic [7:0]  exp_busy;

  function automatic int eff_pend(input logic [2:0] r);
    int p = m_pend[r];
`ifdef WB_BYPASS_EN
    if (bus.wb_we === 1'b1 && bus.wb_idx == r && p == 1) p = 0;
`endif
    return p;
  endfunction

  function automatic void model_comb();
    bit blocked;
    blocked = (eff_pend(m_s1) != 0) || (!m_ctrl[6] && eff_pend(m_s2) != 0)
              || (m_we && eff_pend(m_d) == PendMax);
    m_hazard      = m_hv && blocked;
    exp_out_valid = m_hv && !blocked;
    exp_in_ready  = bus.flush || !m_hv || (exp_out_valid && bus.out_ready);
    for (int r = 0; r < 8; r++) exp_busy[r] = (m_pend[r] != 0);
  endfunction

  function automatic void model_update();
    bit iss, acc;
    if (!rst) begin
      for (int r = 0; r < 8; r++) m_pend[r] = 0;
      m_hv = 0; m_ctrl = '0; m_imm = '0; m_s1 = '0; m_s2 = '0; m_d = '0; m_we = 0;
      m_stall = 0; m_uf = 0;
      return;
    end
    iss = exp_out_valid && bus.out_ready && !bus.flush;
    acc = bus.in_valid && exp_in_ready && !bus.flush;
    if (m_hazard && m_stall < StallMax) m_stall++;
    if (iss && m_we) m_pend[m_d]++;
    if (bus.wb_we) begin
      if (m_pend[bus.wb_idx] == 0) m_uf = 1;
      else m_pend[bus.wb_idx]--;
    end
    if (bus.flush) m_hv = 0;
    else if (acc) begin
      m_hv = 1; m_ctrl = bus.in_ctrl; m_imm = bus.in_imm;
      m_s1 = bus.in_src1_idx; m_s2 = bus.in_src2_idx; m_d = bus.in_dst_idx; m_we = bus.in_dst_we;
    end else if (iss) m_hv = 0;
  endfunction

  task automatic tick();
    model_comb();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic send(input logic [6:0] c, input logic [31:0] imm, input logic [2:0] s1,
                      input logic [2:0] s2, input logic [2:0] d, input logic we);
    bit done = 0;
    bus.in_valid = 1; bus.in_ctrl = c; bus.in_imm = imm;
    bus.in_src1_idx = s1; bus.in_src2_idx = s2; bus.in_dst_idx = d; bus.in_dst_we = we;
    for (int i = 0; i < 50 && !done; i++) begin
      #2;
      if (bus.in_ready === 1'b1) done = 1;
      tick();
    end
    bus.in_valid = 0;
    n_checks++;
    if (!done) begin n_fail++; $display("FAIL send_timeout: in_ready stayed low, want 1"); end
  endtask

  task automatic test_reset();
    rst = 0;
    tick(); tick();
    rst = 1;
    #2;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    n_checks++;
    if (bus.busy_vec !== 8'h00) begin n_fail++; $display("FAIL reset_busy: got %h want 00", bus.busy_vec); end
    n_checks++;
    if (bus.stall_cnt !== 16'd0 || bus.wb_underflow !== 1'b0) begin
      n_fail++; $display("FAIL reset_stat: got stall %0d uf %b want 0 0", bus.stall_cnt, bus.wb_underflow);
    end
    n_checks++;
    if ({bus.out_ctrl, bus.out_imm, bus.out_src1_idx, bus.out_src2_idx, bus.out_dst_idx,
         bus.out_dst_we} !== 52'd0) begin
      n_fail++; $display("FAIL reset_fields: got %h want 0", bus.out_imm);
    end
    tick();
  endtask

  task automatic test_first_issue();
    bus.out_ready = 1;
    send(7'h00, 32'h11, 3'd1, 3'd2, 3'd3, 1'b1);
    #2;
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_src1_idx !== 3'd1 || bus.out_dst_idx !== 3'd3) begin
      n_fail++; $display("FAIL first_offer: got v=%b s1=%0d d=%0d want 1 1 3",
                         bus.out_valid, bus.out_src1_idx, bus.out_dst_idx);
    end
    tick();
    #2;
    n_checks++;
    if (bus.busy_vec !== 8'h08) begin n_fail++; $display("FAIL first_busy: got %h want 08", bus.busy_vec); end
  endtask

  task automatic test_raw_stall();
    send(7'h00, 32'h22, 3'd3, 3'd0, 3'd0, 1'b0);
    #2;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.stall_cnt !== 16'd0) begin
      n_fail++; $display("FAIL raw_held: got v=%b stall=%0d want 0 0", bus.out_valid, bus.stall_cnt);
    end
    tick();
    #2;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.stall_cnt !== 16'd1) begin
      n_fail++; $display("FAIL raw_stall1: got v=%b stall=%0d want 0 1", bus.out_valid, bus.stall_cnt);
    end
    tick();
    bus.wb_we = 1; bus.wb_idx = 3'd3;
    #2;
    n_checks++;
`ifdef WB_BYPASS_EN
    if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL raw_wb_cycle: got %b want 1", bus.out_valid); end
`else
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL raw_wb_cycle: got %b want 0", bus.out_valid); end
`endif
    tick();
    bus.wb_we = 0;
    #2;
    n_checks++;
`ifdef WB_BYPASS_EN
    if (bus.out_valid !== 1'b0 || bus.stall_cnt !== 16'(RawStalls)) begin
      n_fail++; $display("FAIL raw_after_wb: got v=%b stall=%0d want 0 %0d", bus.out_valid, bus.stall_cnt, RawStalls);
    end
`else
    if (bus.out_valid !== 1'b1 || bus.stall_cnt !== 16'(RawStalls)) begin
      n_fail++; $display("FAIL raw_after_wb: got v=%b stall=%0d want 1 %0d", bus.out_valid, bus.stall_cnt, RawStalls);
    end
`endif
    tick();
    #2;
    n_checks++;
    if (bus.busy_vec !== 8'h00 || bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL raw_drained: got busy=%h v=%b want 00 0", bus.busy_vec, bus.out_valid);
    end
  endtask

  task automatic test_imm_no_stall();
    send(7'h00, 32'h0, 3'd0, 3'd0, 3'd3, 1'b1);
    send(7'h40, 32'hDEADBEEF, 3'd1, 3'd3, 3'd2, 1'b0);
    bus.out_ready = 0;
    #2;
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_imm !== 32'hDEADBEEF || bus.busy_vec !== 8'h08) begin
      n_fail++; $display("FAIL imm_offer: got v=%b imm=%h busy=%h want 1 deadbeef 08",
                         bus.out_valid, bus.out_imm, bus.busy_vec);
    end
    tick();
    bus.out_ready = 1;
    #2;
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.stall_cnt !== 16'(RawStalls)) begin
      n_fail++; $display("FAIL imm_nostall: got v=%b stall=%0d want 1 %0d", bus.out_valid, bus.stall_cnt, RawStalls);
    end
    tick();
    bus.wb_we = 1; bus.wb_idx = 3'd3;
    tick();
    bus.wb_we = 0;
  endtask

  task automatic test_pend_max();
    for (int i = 0; i < 4; i++) send(7'h00, 32'(i), 3'd0, 3'd0, 3'd5, 1'b1);
    #2;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.busy_vec !== 8'h20) begin
      n_fail++; $display("FAIL max_stall: got v=%b busy=%h want 0 20", bus.out_valid, bus.busy_vec);
    end
    tick();
    bus.wb_we = 1; bus.wb_idx = 3'd5;
    #2;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL max_wb_cycle: got %b want 0", bus.out_valid); end
    tick();
    bus.wb_we = 0;
    #2;
    n_checks++;
    if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL max_release: got %b want 1", bus.out_valid); end
    tick();
    for (int i = 0; i < 3; i++) begin
      bus.wb_we = 1; bus.wb_idx = 3'd5;
      tick();
    end
    bus.wb_we = 0;
    #2;
    n_checks++;
    if (bus.busy_vec !== 8'h00) begin n_fail++; $display("FAIL max_drain: got %h want 00", bus.busy_vec); end
  endtask

  task automatic test_same_cycle_underflow();
    send(7'h00, 32'h0, 3'd0, 3'd0, 3'd4, 1'b1);
    send(7'h00, 32'h0, 3'd0, 3'd0, 3'd4, 1'b1);
    bus.wb_we = 1; bus.wb_idx = 3'd4;
    #2;
    n_checks++;
    if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL same_offer: got %b want 1", bus.out_valid); end
    tick();
    bus.wb_we = 0;
    #2;
    n_checks++;
    if (bus.busy_vec !== 8'h10 || bus.wb_underflow !== 1'b0) begin
      n_fail++; $display("FAIL same_cycle: got busy=%h uf=%b want 10 0", bus.busy_vec, bus.wb_underflow);
    end
    tick();
    bus.wb_we = 1; bus.wb_idx = 3'd6;
    tick();
    bus.wb_we = 0;
    #2;
    n_checks++;
    if (bus.wb_underflow !== 1'b1 || bus.busy_vec !== 8'h10) begin
      n_fail++; $display("FAIL underflow_set: got uf=%b busy=%h want 1 10", bus.wb_underflow, bus.busy_vec);
    end
    tick(); tick();
    #2;
    n_checks++;
    if (bus.wb_underflow !== 1'b1) begin n_fail++; $display("FAIL underflow_sticky: got %b want 1", bus.wb_underflow); end
    tick();
    bus.wb_we = 1; bus.wb_idx = 3'd4;
    tick();
    bus.wb_we = 0;
  endtask

  task automatic test_flush_and_reset();
    send(7'h00, 32'h0, 3'd0, 3'd0, 3'd1, 1'b1);
    send(7'h00, 32'h0, 3'd1, 3'd0, 3'd0, 1'b0);
    bus.flush = 1;
    bus.in_valid = 1; bus.in_src1_idx = 3'd0; bus.in_src2_idx = 3'd0;
    bus.in_dst_idx = 3'd7; bus.in_dst_we = 1; bus.in_ctrl = 7'h00;
    #2;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL flush_cycle: got v=%b rdy=%b want 0 1", bus.out_valid, bus.in_ready);
    end
    tick();
    bus.flush = 0; bus.in_valid = 0;
    #2;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.busy_vec !== 8'h02) begin
      n_fail++; $display("FAIL flush_after: got v=%b busy=%h want 0 02", bus.out_valid, bus.busy_vec);
    end
    tick();
    #2;
    n_checks++;
    if (bus.busy_vec !== 8'h02) begin n_fail++; $display("FAIL flush_no_accept: got %h want 02", bus.busy_vec); end
    send(7'h00, 32'h0, 3'd1, 3'd0, 3'd0, 1'b0);
    tick();
    rst = 0;
    tick();
    #2;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy_vec !== 8'h00 ||
        bus.stall_cnt !== 16'd0 || bus.wb_underflow !== 1'b0) begin
      n_fail++; $display("FAIL midreset: got v=%b rdy=%b busy=%h stall=%0d uf=%b want 0 1 00 0 0",
                         bus.out_valid, bus.in_ready, bus.busy_vec, bus.stall_cnt, bus.wb_underflow);
    end
    rst = 1;
    tick();
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1;
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1; bus.in_ctrl = 7'h40; bus.in_imm = 32'hB000_0000 + 32'(i);
      bus.in_src1_idx = 3'd0; bus.in_src2_idx = 3'd0; bus.in_dst_idx = 3'd0; bus.in_dst_we = 0;
      #2;
      n_checks++;
      if (bus.in_ready !== 1'b1 ||
          (i > 0 && (bus.out_valid !== 1'b1 || bus.out_imm !== 32'hB000_0000 + 32'(i - 1)))) begin
        n_fail++; $display("FAIL b2b_%0d: got rdy=%b v=%b imm=%h want 1 1 %h", i, bus.in_ready,
                           bus.out_valid, bus.out_imm, 32'hB000_0000 + 32'(i - 1));
      end
      tick();
    end
    bus.in_valid = 0;
    #2;
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_imm !== 32'hB000_0005) begin
      n_fail++; $display("FAIL b2b_last: got v=%b imm=%h want 1 b0000005", bus.out_valid, bus.out_imm);
    end
    tick();
  endtask

  task automatic test_random();
    int pend_list[$];
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bus.in_valid    = ($urandom_range(99) < 60);
      bus.in_ctrl     = 7'($urandom);
      bus.in_imm      = $urandom;
      bus.in_src1_idx = 3'($urandom);
      bus.in_src2_idx = 3'($urandom);
      bus.in_dst_idx  = 3'($urandom);
      bus.in_dst_we   = ($urandom_range(99) < 70);
      bus.out_ready   = ($urandom_range(99) < 75);
      bus.flush       = ($urandom_range(99) < 4);
      pend_list.delete();
      for (int r = 0; r < 8; r++) if (m_pend[r] != 0) pend_list.push_back(r);
      bus.wb_we = 0; bus.wb_idx = 3'($urandom);
      if (pend_list.size() != 0 && $urandom_range(99) < 45) begin
        bus.wb_we = 1; bus.wb_idx = 3'(pend_list[$urandom_range(pend_list.size() - 1)]);
      end else if ($urandom_range(99) < 2) begin
        bus.wb_we = 1;
      end
      #2;
      model_comb();
      n_checks++;
      if (bus.out_valid !== exp_out_valid || bus.in_ready !== exp_in_ready) begin
        n_fail++; $display("FAIL rnd_hs@%0d: got v=%b rdy=%b want %b %b", cyc, bus.out_valid,
                           bus.in_ready, exp_out_valid, exp_in_ready);
      end
      n_checks++;
      if (bus.busy_vec !== exp_busy || bus.stall_cnt !== 16'(m_stall) || bus.wb_underflow !== m_uf) begin
        n_fail++; $display("FAIL rnd_stat@%0d: got busy=%h stall=%0d uf=%b want %h %0d %b", cyc,
                           bus.busy_vec, bus.stall_cnt, bus.wb_underflow, exp_busy, m_stall, m_uf);
      end
      n_checks++;
      if ({bus.out_ctrl, bus.out_imm, bus.out_src1_idx, bus.out_src2_idx, bus.out_dst_idx,
           bus.out_dst_we} !== {m_ctrl, m_imm, m_s1, m_s2, m_d, m_we}) begin
        n_fail++; $display("FAIL rnd_fields@%0d: got imm=%h d=%0d want %h %0d", cyc, bus.out_imm,
                           bus.out_dst_idx, m_imm, m_d);
      end
      tick();
    end
    bus.in_valid = 0; bus.wb_we = 0; bus.flush = 0;
  endtask

  initial begin
    rst = 0;
    bus.flush = 0; bus.in_valid = 0; bus.in_ctrl = '0; bus.in_imm = '0;
    bus.in_src1_idx = '0; bus.in_src2_idx = '0; bus.in_dst_idx = '0; bus.in_dst_we = 0;
    bus.out_ready = 0; bus.wb_we = 0; bus.wb_idx = '0;
    for (int r = 0; r < 8; r++) m_pend[r] = 0;
    test_reset();
    test_first_issue();
    test_raw_stall();
    test_imm_no_stall();
    test_pend_max();
    test_same_cycle_underflow();
    test_flush_and_reset();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end
endmodule
